arbitro_escrita_br: RTL
=======================

# arbitro_escrita_br

Write-port arbiter and scoreboard for the 4×16 register bank. Two writeback sources share the bank's single write port: Req0 is ALU writeback and Req1 is memory load. The block arbitrates them round-robin, registers the winner onto Hab_Escrita/Sel_SC/E, and keeps a per-register pending-write counter. The issue stage uses that counter to detect read-after-write hazards on read ports A and B.

## Interface
Parameters:
- bits_palavra, 16, data word width
- end_registros, 2, register address width
- num_registros, 4, number of registers (2^end_registros)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock
- Req0_Valid, Req1_Valid  in  1  write request valid
- Req0_End, Req1_End  in  end_registros  destination register
- Req0_Dado, Req1_Dado  in  bits_palavra  write data
- Req0_Ready, Req1_Ready  out  1  request accepted this cycle (combinational)
- Hab_Escrita  out  1  registered write enable to bank
- Sel_SC  out  end_registros  registered write address to bank
- E  out  bits_palavra  registered write data to bank
- Reserva_Valid  in  1  issue stage reserves a destination register
- Reserva_End  in  end_registros  register being reserved
- Reserva_Ready  out  1  reservation accepted (combinational)
- Ocupado  out  num_registros  bit i = register i has ≥1 pending write
- Sel_SA, Sel_SB  in  end_registros  read addresses presented to bank
- Conflito_A, Conflito_B  out  1  hazard on port A/B (combinational)
- Bypass_A, Bypass_B  out  1  forward E instead of bank output (see Configuration)

## Operation
Handshake:
- A transfer occurs when Valid and Ready are both high.
- Requester holds Valid, End and Dado stable until Ready.
- Ready is never high without its Valid.

Arbitration:
- Only one request is valid: it is granted.
- Both requests are valid: the requester not granted last is granted.
- Pointer `ultimo` updates only on a transfer.
- Both Ready outputs are low while reset is high.

Write stage:
- On a transfer: Hab_Escrita←1, Sel_SC←End, E←Dado.
- No transfer: Hab_Escrita←0; Sel_SC and E hold their values.

Scoreboard:
- Each register has a 2-bit counter `pend[i]`, range 0..3.
- Reserve: a transfer on Reserva_Valid & Reserva_Ready increments pend[Reserva_End].
- Commit: a cycle with Hab_Escrita high decrements pend[Sel_SC].
- Reserve and commit on the same register in the same cycle: counter unchanged.
- Commit with pend=0: counter stays 0 (no underflow). This is a legal unreserved write.
- Reserva_Ready = ~reset & (pend[Reserva_End] != 3, or a commit to the same register this cycle).
- Ocupado[i] = (pend[i] != 0).
- Conflito_A = Ocupado[Sel_SA] & ~Bypass_A; Conflito_B is defined the same way.

## Timing
- Reset values: Hab_Escrita=0, Sel_SC=0, E=0, all pend=0, Ocupado=0, `ultimo`=Req1 (so Req0 wins the first tie), Bypass_A/B=0.
- Latency: transfer in cycle N → Hab_Escrita high in N+1 → bank updated at end of N+1.
- Throughput is one write per cycle. Back-to-back ties alternate Req0, Req1, Req0, and so on.
- Reserve in cycle N → Ocupado set from N+1.
- Commit in N+1 → Ocupado clears from N+2, when the count reaches 0.
- Reset mid-operation: any write pending in the output register is dropped (Hab_Escrita=0 next cycle), and all counters clear.
- A requester whose Valid is high during reset must hold it; it may be granted in the first cycle after reset.

## Configuration
Macro: ARB_BR_BYPASS_EN.
- Defined: Bypass_A = Hab_Escrita & (Sel_SC == Sel_SA) & (pend[Sel_SA] == 1); Bypass_B is defined the same way. The consumer reads E instead of bank output A/B, and Conflito is suppressed for that port.
- Undefined: Bypass_A/B are tied to 0. Conflito stays high until the cycle after the last pending commit.

## Test plan
- Reset, then Req0_Valid only: End=2, Dado=0xABCD → Req0_Ready=1 in the same cycle; next cycle Hab_Escrita=1, Sel_SC=2, E=0xABCD.
- Both Valid for 4 cycles (Req0 End=1, Req1 End=3) → grants Req0, Req1, Req0, Req1; Hab_Escrita high for 4 consecutive cycles.
- Reserve r1 three times → pend=3, Reserva_Ready=0 for r1. A commit to r1 plus a simultaneous reserve → pend stays 3. Three further commits → Ocupado[1]=0.
- Reserve r2, Sel_SA=2 → Conflito_A=1.
  - Commit r2: with ARB_BR_BYPASS_EN, Bypass_A=1 and Conflito_A=0 in the commit cycle.
  - Without the macro, Conflito_A=1 in the commit cycle and 0 the next cycle.
- Unreserved write to r0 → pend[0] stays 0, no underflow.
- Reset asserted in the cycle after a transfer → Hab_Escrita=0, Ocupado=0; Req0 wins the first tie after reset.

Source files
------------

// File: rtl/arbitro_escrita_br.sv
// Round-robin arbiter for the register-bank write port plus a per-register pending-write scoreboard.
// Optional write-stage forwarding to read ports A/B is enabled by defining ARB_BR_BYPASS_EN.
module arbitro_escrita_br #(
    parameter int unsigned bits_palavra  = 16,
    parameter int unsigned end_registros = 2,
    parameter int unsigned num_registros = 4
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     Req0_Valid,
    input  logic [end_registros-1:0] Req0_End,
    input  logic [bits_palavra-1:0]  Req0_Dado,
    output logic                     Req0_Ready,

    input  logic                     Req1_Valid,
    input  logic [end_registros-1:0] Req1_End,
    input  logic [bits_palavra-1:0]  Req1_Dado,
    output logic                     Req1_Ready,

    output logic                     Hab_Escrita,
    output logic [end_registros-1:0] Sel_SC,
    output logic [bits_palavra-1:0]  E,

    input  logic                     Reserva_Valid,
    input  logic [end_registros-1:0] Reserva_End,
    output logic                     Reserva_Ready,

    output logic [num_registros-1:0] Ocupado,

    input  logic [end_registros-1:0] Sel_SA,
    input  logic [end_registros-1:0] Sel_SB,
    output logic                     Conflito_A,
    output logic                     Conflito_B,
    output logic                     Bypass_A,
    output logic                     Bypass_B
);

    // r_ultimo = 1 means Req1 won the most recent transfer
    logic                     r_ultimo;
    logic                     r_hab;
    logic [end_registros-1:0] r_sel_sc;
    logic [bits_palavra-1:0]  r_e;
    logic [1:0]               r_pend [num_registros];

    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_transfer;
    logic [end_registros-1:0] w_end_sel;
    logic [bits_palavra-1:0]  w_dado_sel;
    logic                     w_reserva;
    logic [num_registros-1:0] w_inc;
    logic [num_registros-1:0] w_dec;
    logic [1:0]               w_pend_d [num_registros];

    // Arbitration
    always_comb begin
        w_grant0 = ~reset & Req0_Valid & (~Req1_Valid | r_ultimo);
        w_grant1 = ~reset & Req1_Valid & (~Req0_Valid | ~r_ultimo);
    end

    assign w_transfer = w_grant0 | w_grant1;
    assign w_end_sel  = w_grant1 ? Req1_End  : Req0_End;
    assign w_dado_sel = w_grant1 ? Req1_Dado : Req0_Dado;
    assign Req0_Ready = w_grant0;
    assign Req1_Ready = w_grant1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ultimo <= 1'b1;
            r_hab    <= 1'b0;
            r_sel_sc <= '0;
            r_e      <= '0;
        end else begin
            r_hab <= w_transfer;
            if (w_transfer) begin
                r_ultimo <= w_grant1;
                r_sel_sc <= w_end_sel;
                r_e      <= w_dado_sel;
            end
        end
    end

    assign Hab_Escrita = r_hab;
    assign Sel_SC      = r_sel_sc;
    assign E           = r_e;

    // Scoreboard: reserve increments, commit (write in the output register) decrements
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_reserva) begin
            w_inc[Reserva_End] = 1'b1;
        end
        if (r_hab) begin
            w_dec[r_sel_sc] = 1'b1;
        end
    end

    assign Reserva_Ready = ~reset & ((r_pend[Reserva_End] != 2'd3) | w_dec[Reserva_End]);
    assign w_reserva     = Reserva_Valid & Reserva_Ready;

    always_comb begin
        for (int i = 0; i < num_registros; i++) begin
            w_pend_d[i] = r_pend[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_pend_d[i] = r_pend[i] + 2'd1;
            end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != 2'd0)) begin
                // an unreserved write arriving at zero leaves the count at zero
                w_pend_d[i] = r_pend[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < num_registros; i++) begin
                r_pend[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < num_registros; i++) begin
                r_pend[i] <= w_pend_d[i];
            end
        end
    end

    always_comb begin
        Ocupado = '0;
        for (int i = 0; i < num_registros; i++) begin
            Ocupado[i] = (r_pend[i] != 2'd0);
        end
    end

`ifdef ARB_BR_BYPASS_EN
    // Forward only when the write in flight is the last outstanding one for that register
    assign Bypass_A = r_hab & (r_sel_sc == Sel_SA) & (r_pend[Sel_SA] == 2'd1);
    assign Bypass_B = r_hab & (r_sel_sc == Sel_SB) & (r_pend[Sel_SB] == 2'd1);
`else
    assign Bypass_A = 1'b0;
    assign Bypass_B = 1'b0;
`endif

    assign Conflito_A = Ocupado[Sel_SA] & ~Bypass_A;
    assign Conflito_B = Ocupado[Sel_SB] & ~Bypass_B;

endmodule
